// File: rtl/mem_scan_pkg.sv
// Board-wide definitions shared by the board writer and the scan engine:
// cell encodings, board geometry, scan FSM states and a saturating counter helper.
package mem_scan_pkg;

  localparam int BOARD_ADDR_W = 6;
  localparam int BOARD_CELLS  = 64;

  localparam logic [1:0] CELL_EMPTY   = 2'b00;
  localparam logic [1:0] CELL_BLACK   = 2'b01;
  localparam logic [1:0] CELL_WHITE   = 2'b10;
  localparam logic [1:0] CELL_INVALID = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SCAN  = 2'b01,
    ST_DRAIN = 2'b10
  } scan_state_e;

  function automatic logic [6:0] sat_inc(input logic [6:0] v, input logic [6:0] lim);
    return (v >= lim) ? v : v + 7'd1;
  endfunction

endpackage

// File: rtl/mem_scan_fifo2.sv
// Two-entry synchronous FIFO for RAM returns; the head entry is a register
// so downstream sees registered data and the count directly gives validity.
module scan_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] r_head;
  logic [W-1:0] r_tail;
  logic [1:0]   r_count;

  // Head/tail storage and occupancy; a push into an empty or draining FIFO lands in the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= {W{1'b0}};
      r_tail  <= {W{1'b0}};
      r_count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= din;
          else                 r_tail <= din;
          if (r_count != 2'd2) r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd2) begin
            r_head <= r_tail;
            r_tail <= din;
          end else begin
            r_head <= din;
          end
        end
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_head;
  assign count = r_count;

endmodule

// File: rtl/mem_scan.sv
// Sequential board RAM reader: streams {addr, cell} beats for cells 0..63
// over valid/ready and keeps running black/white stone counts.
module mem_scan
  import mem_scan_pkg::*;
#(
  parameter int CELLS      = BOARD_CELLS,
  parameter int ADDR_W     = BOARD_ADDR_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              ram_rd,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [1:0]        ram_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [1:0]        out_data,
  output logic [ADDR_W:0]   black_cnt,
  output logic [ADDR_W:0]   white_cnt,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W:0]   MAX_CNT    = (ADDR_W + 1)'(CELLS);
  localparam logic [2:0]        FIFO_LIMIT = 3'(FIFO_DEPTH);

  scan_state_e         r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_cap_addr;
  logic                r_inflight;
  logic [ADDR_W:0]     r_black;
  logic [ADDR_W:0]     r_white;
  logic                r_busy;
  logic                r_done;

  logic                w_pop;
  logic                w_rd;
  logic [2:0]          w_level;
  logic [1:0]          w_count;
  logic [ADDR_W+1:0]   w_head;

  assign w_pop     = out_valid & out_ready;
  assign out_valid = (w_count != 2'd0);
  assign out_addr  = w_head[ADDR_W+1:2];
  assign out_data  = w_head[1:0];

  // Issue a read only if buffered + in-flight cells, less this cycle's pop, leave FIFO room.
  always_comb begin
    w_level = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    w_rd    = (r_state == ST_SCAN) && (w_level < FIFO_LIMIT);
  end

  // Return path: remember which address the RAM is answering next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
      r_cap_addr <= {ADDR_W{1'b0}};
    end else begin
      r_inflight <= w_rd;
      if (w_rd) r_cap_addr <= r_addr;
    end
  end

  scan_fifo2 #(.W(ADDR_W + 2)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (r_inflight),
    .pop   (w_pop),
    .din   ({r_cap_addr, ram_q}),
    .dout  (w_head),
    .count (w_count)
  );

  // Scan control: FSM, read address, stone counters and busy/done flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_addr  <= {ADDR_W{1'b0}};
      r_black <= {(ADDR_W + 1){1'b0}};
      r_white <= {(ADDR_W + 1){1'b0}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      if (w_pop) begin
        if (out_data == CELL_BLACK)      r_black <= sat_inc(r_black, MAX_CNT);
        else if (out_data == CELL_WHITE) r_white <= sat_inc(r_white, MAX_CNT);
        else                             r_black <= r_black;
      end
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_SCAN;
            r_addr  <= {ADDR_W{1'b0}};
            r_black <= {(ADDR_W + 1){1'b0}};
            r_white <= {(ADDR_W + 1){1'b0}};
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        ST_SCAN: begin
          if (w_rd) begin
            r_addr <= r_addr + {{(ADDR_W - 1){1'b0}}, 1'b1};
            if (r_addr == LAST_ADDR) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_pop && (out_addr == LAST_ADDR)) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ram_rd    = w_rd;
  assign ram_addr  = r_addr;
  assign black_cnt = r_black;
  assign white_cnt = r_white;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_mem_scan.sv
// Scoreboard bench for mem_scan: a RAM model, an expected-beat queue filled
// from the board contents at start, and a decoupled output monitor.
module tb_mem_scan;
  import mem_scan_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, start, ram_rd, out_valid, out_ready, busy, done;
  logic [5:0] ram_addr, out_addr;
  logic [1:0] ram_q, out_data;
  logic [6:0] black_cnt, white_cnt;

  logic [1:0] mem [64];
  logic [7:0] exp_q [$];
  int checks = 0, errors = 0;
  int cyc = 0, start_cyc = 0;
  int issued = 0, accepted = 0, first_valid = -1;
  int mon_occ;
  logic mon_pop;

  mem_scan dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ram_rd(ram_rd), .ram_addr(ram_addr),
    .ram_q(ram_q), .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .black_cnt(black_cnt), .white_cnt(white_cnt),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (ram_rd) ram_q <= mem[ram_addr];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc - start_cyc);
    end
  endtask

  // Monitor: read-issue rule, read address order, and beat-by-beat scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        mon_pop = out_valid & out_ready;
        mon_occ = issued - accepted;
        if (ram_rd) begin
          check("issue_rule", 32'((mon_occ - int'(mon_pop)) < 2), 32'd1);
          check("rd_addr", 32'(ram_addr), 32'(issued % 64));
          issued++;
        end
        if (out_valid) begin
          if (first_valid < 0) first_valid = cyc - start_cyc;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_beat: got addr %0d data %0d with nothing expected", out_addr, out_data);
          end else begin
            check("beat", 32'({out_addr, out_data}), 32'(exp_q[0]));
            if (out_ready) begin
              void'(exp_q.pop_front());
              accepted++;
            end
          end
        end
      end
    end
  end

  function automatic logic ready_for(input int mode, input int n);
    case (mode)
      0:       return 1'b1;
      1:       return (n >= 20 && n < 40) ? 1'b0 : (n % 2 == 0);
      default: return ($urandom_range(0, 3) != 0);
    endcase
  endfunction

  task automatic fill(input int mode);
    for (int i = 0; i < 64; i++) begin
      case (mode)
        0:       mem[i] = CELL_EMPTY;
        1:       mem[i] = i[1:0];
        2:       mem[i] = (i == 63) ? CELL_WHITE : CELL_BLACK;
        default: mem[i] = 2'($urandom_range(0, 3));
      endcase
    end
  endtask

  task automatic do_scan(input int rmode, input bit extra, input int abort_at);
    int n, eb, ew;
    bit aborted;
    eb = 0; ew = 0; aborted = 1'b0; n = 0;
    @(posedge clk); #1;
    start = 1'b1; start_cyc = cyc; issued = 0; accepted = 0; first_valid = -1;
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back({6'(i), mem[i]});
      if (mem[i] == CELL_BLACK) eb++;
      else if (mem[i] == CELL_WHITE) ew++;
    end
    out_ready = ready_for(rmode, 0);
    forever begin
      @(posedge clk); #1;
      n = cyc - start_cyc;
      start = extra && (n == 10 || n == 66);
      if (n == 1) begin
        check("start_done_clr", 32'(done), 32'd0);
        check("start_busy", 32'(busy), 32'd1);
        check("start_cnt_clr", 32'({black_cnt, white_cnt}), 32'd0);
      end
      if (n == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_outputs", {ram_rd, ram_addr, out_valid, out_addr, out_data,
                                black_cnt, white_cnt, busy, done}, 32'd0);
        exp_q.delete();
        aborted = 1'b1;
        break;
      end
      if (done) break;
      if (n > 3000) begin
        checks++; errors++;
        $display("FAIL timeout: done not seen after %0d cycles", n);
        break;
      end
      out_ready = ready_for(rmode, n);
    end
    start = 1'b0;
    if (!aborted) begin
      if (rmode == 0) begin
        check("done_cycle", 32'(n), 32'd67);
        check("first_valid_cycle", 32'(first_valid), 32'd3);
      end
      check("black_cnt", 32'(black_cnt), 32'(eb));
      check("white_cnt", 32'(white_cnt), 32'(ew));
      check("beats_left", 32'(exp_q.size()), 32'd0);
      check("beats_accepted", 32'(accepted), 32'd64);
      check("busy_end", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {ram_rd, ram_addr, out_valid, out_addr, out_data,
                            black_cnt, white_cnt, busy, done}, 32'd0);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("idle_no_valid", 32'(out_valid), 32'd0);
    end

    fill(0); do_scan(0, 1'b0, -1);
    check("empty_black", 32'(black_cnt), 32'd0);
    check("empty_white", 32'(white_cnt), 32'd0);

    fill(1); do_scan(0, 1'b0, -1);
    check("pattern_black", 32'(black_cnt), 32'd16);
    check("pattern_white", 32'(white_cnt), 32'd16);

    do_scan(1, 1'b0, -1);
    check("stall_black", 32'(black_cnt), 32'd16);
    check("stall_white", 32'(white_cnt), 32'd16);

    do_scan(0, 1'b1, -1);
    check("extra_start_done", 32'(done), 32'd1);
    check("extra_start_black", 32'(black_cnt), 32'd16);
    do_scan(0, 1'b0, -1);

    fill(3); do_scan(2, 1'b0, 30);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check("post_abort_valid", 32'(out_valid), 32'd0);
      check("post_abort_busy", 32'(busy), 32'd0);
    end
    do_scan(2, 1'b0, -1);

    fill(2); do_scan(2, 1'b0, -1);
    check("allblack_black", 32'(black_cnt), 32'd63);
    check("allblack_white", 32'(white_cnt), 32'd1);
    check("allblack_done", 32'(done), 32'd1);

    repeat (2) begin
      fill(3); do_scan(2, 1'b0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
